// File: rtl/seg7_pkg.sv
// +----------------------------------------------------------------------+
// | seg7_pkg : glyph table, segment and FSM state types shared by the    |
// |            seven-segment decode monitor and segment driver.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package seg7_pkg;

   typedef logic [6:0] seg7_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Active-high segments, bit0 = a ... bit6 = g, indexed by hex value.
   localparam seg7_t c_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic seg7_t glyph_of(input logic [3:0] hex);
      return c_GLYPH[hex];
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
// +----------------------------------------------------------------------+
// | seg7_glyph_decode : combinational segment-pattern to hex decode.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_digit,
   output logic       o_illegal
);

   always_comb begin
      o_digit   = 4'd0;
      o_illegal = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i_seg == c_GLYPH[i]) begin
            o_digit   = 4'(i);
            o_illegal = 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/seg7_decode_monitor.sv
// +----------------------------------------------------------------------+
// | seg7_decode_monitor : debounces a 7-segment pattern, decodes it to   |
// | hex, counts accepted changes and measures the change period.         |
// | Period measurement is built only with SEG7_DECODE_MONITOR_PERIOD_EN. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seg7_decode_monitor
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 16,
   parameter int PERIOD_W      = 24
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [6:0]          seg_in,
   output logic [3:0]          digit,
   output logic                digit_valid,
   output logic                illegal,
   output logic [7:0]          change_cnt,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid
);

   localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);

   state_t      r_state;
   seg7_t       r_seg;
   logic        r_seg_vld;
   seg7_t       r_cand;
   seg7_t       r_acc;
   logic        r_have_acc;
   logic [7:0]  r_stab_cnt;
   logic [3:0]  r_digit;
   logic        r_digit_valid;
   logic        r_illegal;
   logic [7:0]  r_change_cnt;

   logic [3:0]  w_dec_digit;
   logic        w_dec_illegal;
   logic        w_stab_hit;
   logic        w_accept_new;

   seg7_glyph_decode u_decode (
      .i_seg     (r_cand),
      .o_digit   (w_dec_digit),
      .o_illegal (w_dec_illegal)
   );

   // A candidate that settles back onto the accepted pattern is not a change.
   assign w_stab_hit   = (r_state == ST_SETTLE) && (r_seg == r_cand) &&
                         ((r_stab_cnt + 8'd1) == c_STABLE);
   assign w_accept_new = w_stab_hit && !(r_have_acc && (r_cand == r_acc));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_seg         <= '0;
         r_seg_vld     <= 1'b0;
         r_cand        <= '0;
         r_acc         <= '0;
         r_have_acc    <= 1'b0;
         r_stab_cnt    <= 8'd0;
         r_digit       <= 4'd0;
         r_digit_valid <= 1'b0;
         r_illegal     <= 1'b0;
         r_change_cnt  <= 8'd0;
      end else begin
         r_seg         <= seg_in;
         r_seg_vld     <= 1'b1;
         r_digit_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_seg_vld) begin
                  r_cand     <= r_seg;
                  r_stab_cnt <= 8'd1;
                  r_state    <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_seg != r_cand) begin
                  r_cand     <= r_seg;
                  r_stab_cnt <= 8'd1;
               end else if (w_stab_hit) begin
                  r_state    <= ST_LOCKED;
                  r_stab_cnt <= 8'd0;
                  if (w_accept_new) begin
                     r_acc         <= r_cand;
                     r_have_acc    <= 1'b1;
                     r_digit       <= w_dec_digit;
                     r_illegal     <= w_dec_illegal;
                     r_digit_valid <= 1'b1;
                     if (r_have_acc) begin
                        r_change_cnt <= r_change_cnt + 8'd1;
                     end
                  end
               end else begin
                  r_stab_cnt <= r_stab_cnt + 8'd1;
               end
            end
            ST_LOCKED: begin
               if (r_seg != r_acc) begin
                  r_cand     <= r_seg;
                  r_stab_cnt <= 8'd1;
                  r_state    <= ST_SETTLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign digit       = r_digit;
   assign digit_valid = r_digit_valid;
   assign illegal     = r_illegal;
   assign change_cnt  = r_change_cnt;

`ifdef SEG7_DECODE_MONITOR_PERIOD_EN
   logic [PERIOD_W-1:0] r_per_cnt;
   logic [PERIOD_W-1:0] r_period;
   logic                r_period_valid;

   // Counter restarts at 1 so that it reads the exact edge distance at the next acceptance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_per_cnt      <= '0;
         r_period       <= '0;
         r_period_valid <= 1'b0;
      end else begin
         r_period_valid <= 1'b0;
         if (w_accept_new) begin
            r_per_cnt <= PERIOD_W'(1);
            if (r_have_acc) begin
               r_period       <= r_per_cnt;
               r_period_valid <= 1'b1;
            end
         end else if (r_per_cnt != '1) begin
            r_per_cnt <= r_per_cnt + PERIOD_W'(1);
         end
      end
   end

   assign period       = r_period;
   assign period_valid = r_period_valid;
`else
   assign period       = '0;
   assign period_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg7_decode_monitor.sv
// +----------------------------------------------------------------------+
// | tb_seg7_decode_monitor : directed vector table plus random patterns  |
// | checked against a run-length reference model.                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seg7_decode_monitor;

   localparam int STABLE = 16;
   localparam int PW     = 7;
   localparam int PMAX   = (1 << PW) - 1;
`ifdef SEG7_DECODE_MONITOR_PERIOD_EN
   localparam bit PER_EN = 1'b1;
`else
   localparam bit PER_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [6:0]    seg_in = 7'd0;
   logic [3:0]    digit;
   logic          digit_valid;
   logic          illegal;
   logic [7:0]    change_cnt;
   logic [PW-1:0] period;
   logic          period_valid;

   always #5 clk = ~clk;

   seg7_decode_monitor #(
      .STABLE_CYCLES (STABLE),
      .PERIOD_W      (PW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .seg_in       (seg_in),
      .digit        (digit),
      .digit_valid  (digit_valid),
      .illegal      (illegal),
      .change_cnt   (change_cnt),
      .period       (period),
      .period_valid (period_valid)
   );

   logic [6:0] glyphs [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: acceptance happens when the run of identical registered
   // samples reaches STABLE and the value differs from the accepted one.
   bit         m_pend_vld;
   logic [6:0] m_pend;
   logic [6:0] m_run_val;
   int         m_run_len;
   bit         m_have;
   logic [6:0] m_acc;
   int         m_cyc;
   int         m_last_acc;
   int         e_digit;
   bit         e_ill;
   bit         e_dv;
   int         e_chg;
   int         e_period;
   bit         e_pv;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void glyph_lookup(input logic [6:0] s, output int d, output bit ill);
      d   = 0;
      ill = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (glyphs[i] == s) begin
            d   = i;
            ill = 1'b0;
         end
      end
   endfunction

   task automatic model_edge(input bit rst, input logic [6:0] drv);
      int diff;
      e_dv = 1'b0;
      e_pv = 1'b0;
      if (rst) begin
         m_pend_vld = 1'b0;
         m_run_len  = 0;
         m_have     = 1'b0;
         m_cyc      = 0;
         m_last_acc = 0;
         e_digit    = 0;
         e_ill      = 1'b0;
         e_chg      = 0;
         e_period   = 0;
      end else begin
         m_cyc++;
         if (m_pend_vld) begin
            if (m_run_len == 0 || m_pend != m_run_val) begin
               m_run_val = m_pend;
               m_run_len = 1;
            end else begin
               m_run_len++;
            end
            if (m_run_len == STABLE && (!m_have || m_run_val != m_acc)) begin
               glyph_lookup(m_run_val, e_digit, e_ill);
               e_dv = 1'b1;
               if (m_have) begin
                  e_chg = (e_chg + 1) % 256;
                  if (PER_EN) begin
                     diff     = m_cyc - m_last_acc;
                     e_period = (diff > PMAX) ? PMAX : diff;
                     e_pv     = 1'b1;
                  end
               end
               m_have     = 1'b1;
               m_acc      = m_run_val;
               m_last_acc = m_cyc;
            end
         end
         m_pend     = drv;
         m_pend_vld = 1'b1;
      end
   endtask

   task automatic tick(input bit rst, input logic [6:0] s);
      rst_n  = !rst;
      seg_in = s;
      @(posedge clk);
      #1;
      model_edge(rst, s);
      check("digit", digit, e_digit);
      check("illegal", illegal, e_ill);
      check("digit_valid", digit_valid, e_dv);
      check("change_cnt", change_cnt, e_chg);
      check("period", period, e_period);
      check("period_valid", period_valid, e_pv);
   endtask

   typedef struct {
      bit         do_rst;
      logic [6:0] seg;
      int         hold;
      int         exp_digit;
      bit         exp_ill;
      int         exp_chg;
      int         pulse_at;
      bit         exp_pv;
      int         exp_per;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{1'b1, 7'h06,  20, 1, 1'b0, 0, 17, 1'b0,   0};
      vecs[1] = '{1'b0, 7'h5B,   5, 1, 1'b0, 0,  0, 1'b0,   0};
      vecs[2] = '{1'b0, 7'h06,  20, 1, 1'b0, 0,  0, 1'b0,   0};
      vecs[3] = '{1'b1, 7'h3F, 100, 0, 1'b0, 0, 17, 1'b0,   0};
      vecs[4] = '{1'b0, 7'h4F, 100, 3, 1'b0, 1, 17, 1'b1, 100};
      vecs[5] = '{1'b0, 7'h3F, 100, 0, 1'b0, 2, 17, 1'b1, 100};
      vecs[6] = '{1'b0, 7'h7F,  20, 8, 1'b0, 3, 17, 1'b1, 100};
      vecs[7] = '{1'b0, 7'h55,  20, 0, 1'b1, 4, 17, 1'b1,  20};

      tick(1'b1, 7'h00);
      tick(1'b1, 7'h00);

      for (int v = 0; v < 8; v++) begin
         int   pulses;
         int   at;
         int   per_seen;
         bit   pv_seen;
         pulses   = 0;
         at       = 0;
         per_seen = 0;
         pv_seen  = 1'b0;
         if (vecs[v].do_rst) begin
            tick(1'b1, vecs[v].seg);
            check("reset digit", digit, 0);
            check("reset change_cnt", change_cnt, 0);
         end
         for (int k = 1; k <= vecs[v].hold; k++) begin
            tick(1'b0, vecs[v].seg);
            if (digit_valid) begin
               pulses++;
               at       = k;
               per_seen = int'(period);
               pv_seen  = period_valid;
            end
         end
         check($sformatf("vec%0d pulses", v), pulses, (vecs[v].pulse_at != 0) ? 1 : 0);
         if (vecs[v].pulse_at != 0) begin
            check($sformatf("vec%0d pulse cycle", v), at, vecs[v].pulse_at);
            check($sformatf("vec%0d period_valid", v), pv_seen, PER_EN ? vecs[v].exp_pv : 1'b0);
            check($sformatf("vec%0d period", v), per_seen, PER_EN ? vecs[v].exp_per : 0);
         end
         check($sformatf("vec%0d digit", v), digit, vecs[v].exp_digit);
         check($sformatf("vec%0d illegal", v), illegal, vecs[v].exp_ill);
         check($sformatf("vec%0d change_cnt", v), change_cnt, vecs[v].exp_chg);
      end

      // Reset in the middle of settling a new candidate.
      for (int k = 0; k < 8; k++) tick(1'b0, 7'h66);
      check("midsettle digit", digit, 0);
      check("midsettle illegal", illegal, 1);
      tick(1'b1, 7'h66);
      check("rst digit", digit, 0);
      check("rst illegal", illegal, 0);
      check("rst change_cnt", change_cnt, 0);
      check("rst period", period, 0);
      begin
         int pulses;
         int pv_cnt;
         pulses = 0;
         pv_cnt = 0;
         for (int k = 1; k <= 20; k++) begin
            tick(1'b0, 7'h66);
            if (digit_valid) pulses++;
            if (period_valid) pv_cnt++;
         end
         check("post-rst pulses", pulses, 1);
         check("post-rst period_valid", pv_cnt, 0);
         check("post-rst digit", digit, 4);
         check("post-rst change_cnt", change_cnt, 0);
      end

      // Randomised patterns, glitches, long holds (period saturation) and resets.
      for (int n = 0; n < 160; n++) begin
         logic [6:0] p;
         int         h;
         if ($urandom_range(0, 3) != 0) p = glyphs[$urandom_range(0, 15)];
         else                           p = 7'($urandom);
         case ($urandom_range(0, 9))
            0:       h = $urandom_range(140, 200);
            1, 2:    h = $urandom_range(1, 4);
            3:       h = STABLE - 1 + $urandom_range(0, 2);
            default: h = $urandom_range(5, 30);
         endcase
         if ($urandom_range(0, 40) == 0) tick(1'b1, p);
         for (int k = 0; k < h; k++) tick(1'b0, p);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
